// File: rtl/pcomp_position_if.sv
// Position-compare register/bus bundle.
//   enable_i  : run gate (rising edge starts a run, low aborts)
//   inp_i     : signed 32-bit position from the adder
//   START, WIDTH, STEP, PULSES, PRE_START, DIR : run configuration
//   out_o     : compare pulse
//   active_o  : run in progress
//   health_o  : 0 ok, 1 position jumped a whole pulse, 2 invalid config
// master drives the inputs and observes the outputs; slave is the compare stage.
interface pcomp_position_if;
  logic               enable_i;
  logic signed [31:0] inp_i;
  logic signed [31:0] START;
  logic        [31:0] WIDTH;
  logic        [31:0] STEP;
  logic        [31:0] PULSES;
  logic        [31:0] PRE_START;
  logic               DIR;
  logic               out_o;
  logic               active_o;
  logic        [1:0]  health_o;

  modport master (
    output enable_i, inp_i, START, WIDTH, STEP, PULSES, PRE_START, DIR,
    input  out_o, active_o, health_o
  );

  modport slave (
    input  enable_i, inp_i, START, WIDTH, STEP, PULSES, PRE_START, DIR,
    output out_o, active_o, health_o
  );
endinterface

// File: rtl/pcomp_position.sv
// Position compare stage: emits PULSES pulses of WIDTH position units starting
// at START, START+STEP, ... as the position travels in direction DIR.
//   clk_i   : system clock
//   reset_i : synchronous active-high reset
//   bus     : pcomp_position_if.slave (config, position in, out/active/health)
// All outputs are registered (one cycle after the deciding position sample).
module pcomp_position (
  input logic             clk_i,
  input logic             reset_i,
  pcomp_position_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ARM, WAIT_RISE, WAIT_FALL} state_t;

  state_t state, state_d;

  logic               en_prev;
  logic signed [33:0] start_q;
  logic        [31:0] width_q, step_q, pulses_q, pre_q;
  logic               dir_q;
  logic signed [33:0] t_q, t_d;      // current pulse start target
  logic        [31:0] n_q, n_d;      // pulses completed this run
  logic               out_q, out_d;
  logic               act_q, act_d;
  logic        [1:0]  health_q, health_d;
  logic               load;

  // 34-bit signed working copies; 34 bits covers START +/- a full 32-bit
  // unsigned distance without wrapping.
  logic signed [33:0] pos, width_s, step_s, pre_s, far_t, next_t;
  logic               rise, cfg_bad, hit_t, hit_far, arm_ok;
  logic        [31:0] n_inc;

  assign pos     = {{2{bus.inp_i[31]}}, bus.inp_i};
  assign width_s = {2'b00, width_q};
  assign step_s  = {2'b00, step_q};
  assign pre_s   = {2'b00, pre_q};

  // Trailing edge of the current pulse and the next pulse start.
  assign far_t  = dir_q ? t_q - width_s : t_q + width_s;
  assign next_t = dir_q ? t_q - step_s  : t_q + step_s;

  assign hit_t   = dir_q ? (pos <= t_q)   : (pos >= t_q);
  assign hit_far = dir_q ? (pos <= far_t) : (pos >= far_t);
  assign arm_ok  = dir_q ? (pos >= start_q + pre_s) : (pos <= start_q - pre_s);

  assign rise    = bus.enable_i & ~en_prev;
  // Pulses must not overlap unless only one is requested.
  assign cfg_bad = (bus.WIDTH == 32'd0) ||
                   ((bus.PULSES != 32'd1) && (bus.STEP <= bus.WIDTH));
  assign n_inc   = n_q + 32'd1;

  always_comb begin
    state_d  = state;
    out_d    = out_q;
    act_d    = act_q;
    health_d = health_q;
    t_d      = t_q;
    n_d      = n_q;
    load     = 1'b0;
    if (state == IDLE) begin
      if (rise) begin
        if (cfg_bad) begin
          health_d = 2'd2;
        end else begin
          health_d = 2'd0;
          act_d    = 1'b1;
          n_d      = 32'd0;
          t_d      = {{2{bus.START[31]}}, bus.START};
          load     = 1'b1;
          state_d  = ARM;
        end
      end
    end else if (!bus.enable_i) begin
      // Abort keeps the health code.
      out_d   = 1'b0;
      act_d   = 1'b0;
      state_d = IDLE;
    end else begin
      case (state)
        ARM: if (arm_ok) state_d = WAIT_RISE;
        WAIT_RISE: begin
          // Leading and trailing edge crossed in one sample: pulse skipped.
          if (hit_far) begin
            health_d = 2'd1;
            out_d    = 1'b0;
            act_d    = 1'b0;
            state_d  = IDLE;
          end else if (hit_t) begin
            out_d   = 1'b1;
            state_d = WAIT_FALL;
          end
        end
        WAIT_FALL: begin
          if (hit_far) begin
            out_d = 1'b0;
            n_d   = n_inc;
            if (pulses_q != 32'd0 && n_inc == pulses_q) begin
              act_d    = 1'b0;
              health_d = 2'd0;
              state_d  = IDLE;
            end else begin
              t_d     = next_t;
              state_d = WAIT_RISE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state    <= IDLE;
      out_q    <= 1'b0;
      act_q    <= 1'b0;
      health_q <= 2'd0;
      n_q      <= 32'd0;
      t_q      <= '0;
      start_q  <= '0;
      width_q  <= '0;
      step_q   <= '0;
      pulses_q <= '0;
      pre_q    <= '0;
      dir_q    <= 1'b0;
    end else begin
      state    <= state_d;
      out_q    <= out_d;
      act_q    <= act_d;
      health_q <= health_d;
      n_q      <= n_d;
      t_q      <= t_d;
      if (load) begin
        start_q  <= {{2{bus.START[31]}}, bus.START};
        width_q  <= bus.WIDTH;
        step_q   <= bus.STEP;
        pulses_q <= bus.PULSES;
        pre_q    <= bus.PRE_START;
        dir_q    <= bus.DIR;
      end
    end
  end

  // Edge detector tracks the raw enable sample, reset or not.
  always_ff @(posedge clk_i) en_prev <= bus.enable_i;

  assign bus.out_o    = out_q;
  assign bus.active_o = act_q;
  assign bus.health_o = health_q;

endmodule

// File: tb/tb_pcomp_position.sv
module tb_pcomp_position;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pcomp_position_if bus();
  pcomp_position dut (.clk_i(clk), .reset_i(rst), .bus(bus));

  int    vectors = 0;
  int    miscompares = 0;
  string tag = "init";

  // Reference model state: run phase and completed pulse count n.
  int     m_phase;   // 0 idle, 1 arming, 2 before pulse, 3 inside pulse
  longint m_n;
  longint m_start, m_width, m_step, m_pulses, m_pre, m_sgn;
  bit     m_prev_en;
  bit     e_out, e_act;
  int     e_h;

  int pulses_seen;
  bit last_out, act_seen;

  function automatic bit reached(longint p, longint x);
    return (m_sgn > 0) ? (p >= x) : (p <= x);
  endfunction

  task automatic model(input bit en, input longint p, input bit r);
    longint tgt;
    if (r) begin
      m_phase = 0; m_n = 0; e_out = 0; e_act = 0; e_h = 0;
    end else if (m_phase == 0) begin
      if (en && !m_prev_en) begin
        if (bus.WIDTH == 0 || (bus.PULSES != 1 && bus.STEP <= bus.WIDTH)) e_h = 2;
        else begin
          m_start = longint'(bus.START); m_width = longint'(bus.WIDTH);
          m_step = longint'(bus.STEP); m_pulses = longint'(bus.PULSES);
          m_pre = longint'(bus.PRE_START); m_sgn = bus.DIR ? -1 : 1;
          m_n = 0; e_h = 0; e_act = 1; m_phase = 1;
        end
      end
    end else if (!en) begin
      e_out = 0; e_act = 0; m_phase = 0;
    end else begin
      tgt = m_start + m_sgn * m_n * m_step;
      if (m_phase == 1) begin
        // Armed once strictly behind START by PRE_START (or equal to that point).
        if (m_sgn * p <= m_sgn * m_start - m_pre) m_phase = 2;
      end else if (m_phase == 2) begin
        if (reached(p, tgt + m_sgn * m_width)) begin
          e_h = 1; e_out = 0; e_act = 0; m_phase = 0;
        end else if (reached(p, tgt)) begin
          e_out = 1; m_phase = 3;
        end
      end else if (reached(p, tgt + m_sgn * m_width)) begin
        e_out = 0; m_n++;
        if (m_pulses != 0 && m_n == m_pulses) begin e_act = 0; m_phase = 0; end
        else m_phase = 2;
      end
    end
    m_prev_en = en;
  endtask

  task automatic cyc(input bit en, input int p, input bit r);
    bus.enable_i = en; bus.inp_i = p; rst = r;
    @(posedge clk);
    model(en, longint'(p), r);
    #1;
    vectors++;
    assert (bus.out_o === e_out && bus.active_o === e_act && bus.health_o === 2'(e_h))
    else begin
      miscompares++;
      $error("FAIL %s pos=%0d: out/act/health=%0b/%0b/%0d expected %0b/%0b/%0d",
             tag, p, bus.out_o, bus.active_o, bus.health_o, e_out, e_act, e_h);
    end
    if (bus.out_o && !last_out) pulses_seen++;
    if (bus.active_o) act_seen = 1;
    last_out = bus.out_o;
  endtask

  task automatic chk(input string name, input longint obs, input longint exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: got %0d expected %0d", name, obs, exp);
    end
  endtask

  task automatic ramp(input int a, input int b);
    int p = a;
    while (p != b) begin
      cyc(1, p, 0);
      p += (b > a) ? 1 : -1;
    end
    cyc(1, b, 0);
  endtask

  task automatic idle(input int k, input int p);
    for (int i = 0; i < k; i++) cyc(0, p, 0);
  endtask

  task automatic cfg(input int s, input int w, input int st, input int np,
                     input int pre, input bit d);
    bus.START = s; bus.WIDTH = w; bus.STEP = st; bus.PULSES = np;
    bus.PRE_START = pre; bus.DIR = d;
  endtask

  initial begin
    bus.enable_i = 0; bus.inp_i = 0;
    cfg(100, 10, 50, 3, 0, 0);
    m_phase = 0; m_n = 0; m_prev_en = 0; e_out = 0; e_act = 0; e_h = 0;
    m_sgn = 1; m_start = 0; m_width = 0; m_step = 0; m_pulses = 0; m_pre = 0;
    pulses_seen = 0; last_out = 0; act_seen = 0;

    tag = "reset";
    cyc(0, 0, 1); cyc(0, 0, 1);
    chk("reset_out", bus.out_o, 0);
    chk("reset_health", bus.health_o, 0);

    tag = "basic_pos";
    idle(2, 0); pulses_seen = 0;
    ramp(0, 300);
    chk("basic_pulse_count", pulses_seen, 3);
    chk("basic_done_active", bus.active_o, 0);

    tag = "negative";
    cfg(-100, 5, 20, 2, 0, 1);
    idle(2, 0); pulses_seen = 0;
    ramp(0, -200);
    chk("neg_pulse_count", pulses_seen, 2);

    tag = "pre_start";
    cfg(100, 10, 50, 1, 20, 0);
    idle(2, 95); pulses_seen = 0;
    ramp(95, 120);
    chk("pre_first_pass", pulses_seen, 0);
    ramp(120, 70);
    ramp(70, 120);
    chk("pre_second_pass", pulses_seen, 1);

    tag = "jump";
    cfg(100, 10, 50, 1, 0, 0);
    idle(2, 80); pulses_seen = 0;
    ramp(80, 90);
    cyc(1, 115, 0); cyc(1, 116, 0);
    chk("jump_health", bus.health_o, 1);
    chk("jump_active", bus.active_o, 0);
    chk("jump_pulses", pulses_seen, 0);

    tag = "invalid";
    cfg(100, 0, 50, 3, 0, 0);
    idle(2, 0); act_seen = 0;
    ramp(0, 20);
    chk("invalid_health", bus.health_o, 2);
    chk("invalid_active_seen", act_seen, 0);

    tag = "abort";
    cfg(100, 10, 50, 3, 0, 0);
    idle(2, 0);
    ramp(0, 103);
    chk("abort_pre_out", bus.out_o, 1);
    cyc(0, 104, 0);
    chk("abort_out", bus.out_o, 0);
    chk("abort_active", bus.active_o, 0);
    chk("abort_health", bus.health_o, 0);

    tag = "reset_mid";
    idle(2, 0);
    ramp(0, 120);
    cyc(1, 121, 1);
    chk("rst_mid_active", bus.active_o, 0);
    idle(2, 0); pulses_seen = 0;
    ramp(0, 300);
    chk("rst_restart_pulses", pulses_seen, 3);

    tag = "unlimited";
    cfg(0, 10, 30, 0, 0, 0);
    idle(2, -5); pulses_seen = 0;
    ramp(-5, 500);
    bus.START = 777;
    ramp(501, 1000);
    chk("unlimited_pulses", pulses_seen, 34);
    chk("unlimited_still_active", bus.active_o, 1);
    idle(2, 1000);

    tag = "random";
    for (int run = 0; run < 6; run++) begin
      int p, sgn, w;
      bit d;
      d = $urandom_range(0, 1);
      sgn = d ? -1 : 1;
      w = $urandom_range(1, 20);
      cfg(int'($urandom_range(0, 1000)) - 500, w, w + int'($urandom_range(1, 40)),
          $urandom_range(0, 4), $urandom_range(0, 30), d);
      if ($urandom_range(0, 5) == 0) bus.STEP = bus.WIDTH;
      if ($urandom_range(0, 7) == 0) bus.WIDTH = 0;
      p = bus.START - sgn * (int'(bus.PRE_START) + int'($urandom_range(0, 50)));
      idle(3, p);
      for (int i = 0; i < 300; i++) begin
        int dp;
        dp = ($urandom_range(0, 39) == 0) ? 30 : int'($urandom_range(0, 9)) - 2;
        p += sgn * dp;
        if ($urandom_range(0, 199) == 0) cyc(1, p, 1);
        else if ($urandom_range(0, 149) == 0) cyc(0, p, 0);
        else cyc(1, p, 0);
      end
      idle(2, p);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pcomp_position.md
Name: pcomp_position

Overview:
- Position-compare stage directly downstream of the adder block.
- Takes the adder's 32-bit signed `out_o` as its position input `inp_i`.
- Emits a train of `PULSES` output pulses as the position crosses `START`, `START+STEP`, `START+2*STEP`, …; each pulse is `WIDTH` position units wide.
- Supports positive or negative travel, an optional pre-start arming distance, and reports errors on `health_o`.

Parameters:
- None. All configuration is via register ports, sampled on the `enable_i` rising edge.

Ports:
- `clk_i` in 1: system clock.
- `reset_i` in 1: synchronous reset, active-high.
- `enable_i` in 1: run gate; rising edge starts a run, low aborts it.
- `inp_i` in 32: signed position (adder `out_o`).
- `START` in 32: signed first pulse position.
- `WIDTH` in 32: unsigned pulse width in position units; 0 is invalid.
- `STEP` in 32: unsigned distance between pulse starts.
- `PULSES` in 32: unsigned pulse count; 0 means unlimited.
- `PRE_START` in 32: unsigned arming distance before `START`.
- `DIR` in 1: 0 = positive travel, 1 = negative travel.
- `out_o` out 1: compare pulse output.
- `active_o` out 1: high while a run is in progress.
- `health_o` out 2: 0 OK, 1 position jumped past a whole pulse, 2 invalid config.

Behaviour:
- Reset (`reset_i`=1 at a `clk_i` edge):
  - `out_o`=0, `active_o`=0, `health_o`=0, state=IDLE, pulse count n=0.
  - Reset wins over any simultaneous event.
- All outputs are registered. A condition met by the `inp_i` sample at edge k appears on the outputs after edge k, i.e. one cycle of latency.
- Arithmetic:
  - All targets and compares use 34-bit signed values, sign-extended from the 32-bit operands. There is no wrap-around.
  - sgn = +1 if `DIR`=0, −1 if `DIR`=1.
  - Target T = `START` + sgn·n·`STEP`.
  - "Reached X" means `inp_i` >= X for `DIR`=0, and `inp_i` <= X for `DIR`=1.
- Configuration is latched on the `enable_i` rising edge (`enable_i`=1, previous sample 0). Register changes during a run are ignored until the next rising edge.
- Config check at the rising edge:
  - Invalid if `WIDTH`=0, or if `PULSES`≠1 and `STEP`<=`WIDTH`.
  - Invalid config: `health_o`=2, stay IDLE, `active_o` stays 0.
  - Valid config: `health_o`=0, `active_o`=1, n=0, go to ARM.
- ARM: wait until the position is on the far side of the pre-start point, i.e. `inp_i` <= `START`−`PRE_START` for `DIR`=0 (mirrored for `DIR`=1). Then go to WAIT_RISE.
  - With `PRE_START`=0 this is the condition "not yet reached `START`"; it can pass on the first cycle.
- WAIT_RISE:
  - If T+sgn·`WIDTH` is reached in the same sample as T: jump error. `health_o`=1, `out_o`=0, `active_o`=0, go IDLE.
  - Else if T is reached: `out_o`=1, go WAIT_FALL.
- WAIT_FALL: when T+sgn·`WIDTH` is reached:
  - `out_o`=0 and n=n+1.
  - If `PULSES`≠0 and n=`PULSES`: `active_o`=0, go IDLE with `health_o`=0.
  - Otherwise go WAIT_RISE with the new T.
- Abort: `enable_i`=0 in any non-IDLE state gives `out_o`=0, `active_o`=0 next cycle and go IDLE. `health_o` is unchanged.
- In IDLE, `health_o` holds its last value until the next rising edge or reset.
- Position reversal is not an error: the state simply waits. `out_o` stays high if reversal happens mid-pulse.
- `enable_i` held high after completion does not restart; a new rising edge is required.
- Reset mid-run gives the full reset values on the next cycle.

Test Plan:
- Basic positive run:
  - Config: `START`=100, `WIDTH`=10, `STEP`=50, `PULSES`=3, `PRE_START`=0, `DIR`=0.
  - Stimulus: `enable_i` rises with `inp_i`=0; `inp_i` ramps +1 per clock to 300.
  - Required: `out_o` high for `inp_i` samples 100–109, 150–159 and 200–209 (one cycle late); `active_o` falls after the sample at 210; `health_o`=0.
- Negative direction:
  - Config: `DIR`=1, `START`=−100, `WIDTH`=5, `STEP`=20, `PULSES`=2.
  - Stimulus: `inp_i` ramps from 0 down to −200.
  - Required: pulses for samples −100..−104 and −120..−124; then idle.
- Pre-start:
  - Config: `START`=100, `PRE_START`=20.
  - Stimulus: `enable_i` rises at `inp_i`=95, ramp up to 120, ramp down to 70, ramp up to 120.
  - Required: no pulse on the first pass; the pulse occurs after the position goes <= 80.
- Jump and config errors:
  - Jump: `inp_i` steps 90→115 with `START`=100, `WIDTH`=10. Required: `health_o`=1, `active_o`=0, no `out_o` pulse.
  - Invalid config: `WIDTH`=0 at enable. Required: `health_o`=2, `active_o` never rises.
- Abort and reset:
  - Abort: `enable_i` drops while `out_o`=1. Required: `out_o`=0 and `active_o`=0 next cycle; `health_o`=0.
  - Reset: assert `reset_i` for one cycle mid-run. Required: all outputs 0, and a re-enable restarts at n=0.
- Unlimited pulses and config latching:
  - Config: `PULSES`=0, `STEP`=30, `WIDTH`=10, `START`=0.
  - Stimulus: ramp to 1000; change `START` mid-run.
  - Required: 34 pulses at 0, 30, …, 990; the `START` change is ignored.
